// File: rtl/return_stack_ctrl.sv
// Sequencer and guard for the return stack: accepts one request at a time,
// tracks occupancy, traps overflow/underflow/illegal ops, and drives the stack.
module return_stack_ctrl #(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [2:0]    req_op,
  input  logic [W-1:0]  req_data,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [W-1:0]  resp_data,
  output logic [1:0]    stk_op,
  output logic [W-1:0]  stk_w,
  output logic          stk_reset,
  input  logic [W-1:0]  stk_top,
  output logic [CW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          err,
  output logic [1:0]    err_code,
  input  logic          err_clr,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CALL   = 3'd1;
  localparam logic [2:0] OP_RET    = 3'd2;
  localparam logic [2:0] OP_TO_R   = 3'd3;
  localparam logic [2:0] OP_FROM_R = 3'd4;
  localparam logic [2:0] OP_PEEK   = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam logic [1:0] STK_HOLD = 2'd0;
  localparam logic [1:0] STK_PUSH = 2'd1;
  localparam logic [1:0] STK_POP  = 2'd3;

  localparam logic [1:0] E_OVER  = 2'd1;
  localparam logic [1:0] E_UNDER = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is in flight.
  logic accept;
  logic is_push;
  logic is_pop;
  logic clr_pulse;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign is_push   = (req_op == OP_CALL) || (req_op == OP_TO_R);
  assign is_pop    = (req_op == OP_RET) || (req_op == OP_FROM_R);
  assign empty     = (depth == '0);
  assign full      = (depth == CW'(DEPTH));
  assign stk_reset = reset || clr_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      depth      <= '0;
      stk_op     <= STK_HOLD;
      stk_w      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      clr_pulse  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      stk_op     <= STK_HOLD;
      clr_pulse  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (req_op == OP_RSVD) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= E_ILL;
            end else if (is_push && full) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= E_OVER;
            end else if ((is_pop || req_op == OP_PEEK) && empty) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= E_UNDER;
            end else if (req_op != OP_NOP) begin
              state <= S_EXEC;
              // stk_top is the pre-pop value here; the stack moves at the negedge.
              if (is_push) begin
                stk_op    <= STK_PUSH;
                stk_w     <= req_data;
                depth     <= depth + CW'(1);
                resp_data <= '0;
              end else if (is_pop) begin
                stk_op    <= STK_POP;
                resp_data <= stk_top;
                depth     <= depth - CW'(1);
              end else if (req_op == OP_PEEK) begin
                resp_data <= stk_top;
              end else begin
                clr_pulse <= 1'b1;
                depth     <= '0;
                resp_data <= '0;
              end
            end
          end
        end
        S_EXEC: begin
          resp_valid <= 1'b1;
          state      <= S_IDLE;
        end
        S_ERR: begin
          if (err_clr) begin
            err      <= 1'b0;
            err_code <= 2'd0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
